// File: rtl/seq_alu.sv
// Sequential ALU: add/sub/logic in one cycle, bit-serial shifts and shift-add multiply.
// Latency: 1 cycle for single-cycle ops and zero-amount shifts, n+1 for shifts by n, WIDTH+1 for MUL.
// Backpressure: start_i is ignored while busy_o=1 (no queuing); a start in the done cycle is accepted.
module seq_alu #(
    parameter  int WIDTH = 8,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [3:0]       op_i,
    input  logic [WIDTH-1:0] rs_i,
    input  logic [WIDTH-1:0] rt_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic [WIDTH-1:0] hi_o,
    output logic             carry_o,
    output logic             neg_o,
    output logic             zero_o
);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_ADDC = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_SUBC = 4'd3;
    localparam logic [3:0] OP_LSL  = 4'd4;
    localparam logic [3:0] OP_LSLC = 4'd5;
    localparam logic [3:0] OP_LSR  = 4'd6;
    localparam logic [3:0] OP_LSRC = 4'd7;
    localparam logic [3:0] OP_ASR  = 4'd8;
    localparam logic [3:0] OP_NOT  = 4'd9;
    localparam logic [3:0] OP_AND  = 4'd10;
    localparam logic [3:0] OP_OR   = 4'd11;
    localparam logic [3:0] OP_CMP  = 4'd12;
    localparam logic [3:0] OP_MUL  = 4'd13;

    localparam logic [SHW:0] CNT_MUL = (SHW+1)'(WIDTH);
    localparam logic [SHW:0] CNT_ONE = (SHW+1)'(1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    // Operation context captured at accept: opcode, carry-in, working operands, step counter.
    logic [3:0]       r_op;
    logic             r_cin;
    logic [WIDTH-1:0] r_a;      // shift register, or multiplicand for MUL
    logic [WIDTH-1:0] r_b;      // multiplier, becomes the low product half
    logic [WIDTH-1:0] r_acc;    // running high product half
    logic [SHW:0]     r_cnt;

    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_hi;
    logic             r_carry;
    logic             r_neg;
    logic             r_zero;

    logic [SHW-1:0]   w_amt;
    logic             w_is_shift;
    logic             w_multi;
    logic             w_accept;
    logic             w_last;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_dif;
    logic [WIDTH-1:0] w_s_res;
    logic [WIDTH-1:0] w_s_hi;
    logic [WIDTH-1:0] w_s_val;
    logic             w_s_c;
    logic             w_s_nz;

    logic             w_fill;
    logic [WIDTH-1:0] w_sh_nxt;
    logic             w_sh_out;
    logic [WIDTH:0]   w_pp;
    logic [WIDTH-1:0] w_mul_hi;
    logic [WIDTH-1:0] w_mul_lo;

    assign w_amt      = rt_i[SHW-1:0];
    assign w_is_shift = (op_i inside {[OP_LSL:OP_ASR]});
    assign w_multi    = (op_i == OP_MUL) || (w_is_shift && (w_amt != '0));
    assign w_accept   = start_i && (r_state != RUN);
    assign w_last     = (r_state == RUN) && (r_cnt == CNT_ONE);

    assign busy_o   = (r_state == RUN);
    assign done_o   = (r_state == DONE);
    assign result_o = r_result;
    assign hi_o     = r_hi;
    assign carry_o  = r_carry;
    assign neg_o    = r_neg;
    assign zero_o   = r_zero;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next state: multi-cycle work goes through RUN, everything else straight to DONE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE, DONE: begin
                if (start_i) w_state_nxt = w_multi ? RUN : DONE;
                else         w_state_nxt = IDLE;
            end
            RUN:     if (r_cnt == CNT_ONE) w_state_nxt = DONE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Single-cycle result path, evaluated directly from the request inputs.
    always_comb begin
        w_sum   = {1'b0, rs_i} + {1'b0, rt_i} + {{WIDTH{1'b0}}, (op_i == OP_ADDC) & r_carry};
        w_dif   = {1'b0, rs_i} - {1'b0, rt_i} - {{WIDTH{1'b0}}, (op_i == OP_SUBC) & r_carry};
        w_s_res = '0;
        w_s_hi  = '0;
        w_s_c   = r_carry;
        w_s_nz  = 1'b1;
        case (op_i)
            OP_ADD, OP_ADDC: begin
                w_s_res = w_sum[WIDTH-1:0];
                w_s_c   = w_sum[WIDTH];
            end
            OP_SUB, OP_SUBC: begin
                w_s_res = w_dif[WIDTH-1:0];
                w_s_c   = w_dif[WIDTH];
            end
            OP_CMP: begin
                // Compare only touches the flags; visible results are kept.
                w_s_res = r_result;
                w_s_hi  = r_hi;
                w_s_c   = w_dif[WIDTH];
            end
            OP_LSL, OP_LSLC, OP_LSR, OP_LSRC, OP_ASR: w_s_res = rs_i;  // zero-amount shift
            OP_NOT: w_s_res = ~rt_i;
            OP_AND: w_s_res = rs_i & rt_i;
            OP_OR:  w_s_res = rs_i | rt_i;
            default: w_s_nz = 1'b0;  // reserved: zero outputs, all flags kept
        endcase
        w_s_val = (op_i == OP_CMP) ? w_dif[WIDTH-1:0] : w_s_res;
    end

    // One shift step and one shift-add multiply step from the captured context.
    always_comb begin
        case (r_op)
            OP_LSLC, OP_LSRC: w_fill = r_cin;
            OP_ASR:           w_fill = r_a[WIDTH-1];
            default:          w_fill = 1'b0;
        endcase
        if ((r_op == OP_LSL) || (r_op == OP_LSLC)) begin
            w_sh_nxt = {r_a[WIDTH-2:0], w_fill};
            w_sh_out = r_a[WIDTH-1];
        end else begin
            w_sh_nxt = {w_fill, r_a[WIDTH-1:1]};
            w_sh_out = r_a[0];
        end
        w_pp     = {1'b0, r_acc} + (r_b[0] ? {1'b0, r_a} : '0);
        w_mul_hi = w_pp[WIDTH:1];
        w_mul_lo = {w_pp[0], r_b[WIDTH-1:1]};
    end

    // Datapath: capture on accept, iterate in RUN, publish results only on the done edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op     <= '0;
            r_cin    <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_hi     <= '0;
            r_carry  <= 1'b0;
            r_neg    <= 1'b0;
            r_zero   <= 1'b0;
        end else if (w_accept) begin
            r_op  <= op_i;
            r_cin <= r_carry;
            r_a   <= rs_i;
            r_b   <= rt_i;
            r_acc <= '0;
            r_cnt <= (op_i == OP_MUL) ? CNT_MUL : {1'b0, w_amt};
            if (!w_multi) begin
                r_result <= w_s_res;
                r_hi     <= w_s_hi;
                r_carry  <= w_s_c;
                if (w_s_nz) begin
                    r_neg  <= w_s_val[WIDTH-1];
                    r_zero <= (w_s_val == '0);
                end
            end
        end else if (r_state == RUN) begin
            r_cnt <= r_cnt - CNT_ONE;
            if (r_op == OP_MUL) begin
                r_acc <= w_mul_hi;
                r_b   <= w_mul_lo;
            end else begin
                r_a <= w_sh_nxt;
            end
            if (w_last) begin
                if (r_op == OP_MUL) begin
                    r_result <= w_mul_lo;
                    r_hi     <= w_mul_hi;
                    r_carry  <= (w_mul_hi != '0);
                    r_neg    <= w_mul_lo[WIDTH-1];
                    r_zero   <= ({w_mul_hi, w_mul_lo} == '0);
                end else begin
                    r_result <= w_sh_nxt;
                    r_hi     <= '0;
                    r_carry  <= w_sh_out;
                    r_neg    <= w_sh_nxt[WIDTH-1];
                    r_zero   <= (w_sh_nxt == '0);
                end
            end
        end
    end

endmodule
